// File: rtl/audio_link_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | audio_link_pkg : shared types and constants for the audio link block  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package audio_link_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } link_state_e;

  localparam logic [7:0] LINK_MARKER = 8'hAA;
  localparam int         FRAME_BITS  = 40;

  function automatic logic marker_hit(input logic [FRAME_BITS-1:0] win);
    return win[FRAME_BITS-1 -: 8] == LINK_MARKER;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_link_supervisor_sck_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | link_sck_edge : 2-FF synchronisers for sck/sd plus sck rising strobe  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module link_sck_edge (
  input  logic clk,
  input  logic reset,
  input  logic sck_i,
  input  logic sd_i,
  output logic bit_evt_o,
  output logic bit_val_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] sd_sync_q;
  logic       sck_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= 2'b00;
      sd_sync_q  <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck_i};
      sd_sync_q  <= {sd_sync_q[0], sd_i};
      sck_prev_q <= sck_sync_q[1];
    end
  end

  // sd travels through the same depth as sck so the strobe and data stay aligned
  assign bit_evt_o = sck_sync_q[1] & ~sck_prev_q;
  assign bit_val_o = sd_sync_q[1];

endmodule
`default_nettype wire

// File: rtl/audio_link_supervisor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | audio_link_supervisor : frame-lock, watchdog and mute for the serial  |
// | audio link. Optional error counter: define AUDIO_LINK_ERRCNT_EN.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module audio_link_supervisor
  import audio_link_pkg::*;
#(
  parameter int LOCK_FRAMES    = 4,
  parameter int MISS_MAX       = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sd,
  output logic [15:0] left_out,
  output logic [15:0] right_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        locked
`ifdef AUDIO_LINK_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [1:0] S_HUNT   = HUNT;
  localparam logic [1:0] S_CHECK  = CHECK;
  localparam logic [1:0] S_LOCKED = LOCKED;

  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
  localparam logic [5:0]        LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [3:0]        LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0]        MISS_N   = 4'(MISS_MAX);

  logic                  w_evt;
  logic                  w_bit;
  logic [FRAME_BITS-1:0] w_shift;
  logic                  w_hit;
  logic                  w_boundary;
  logic                  w_timeout;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_mute;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] win_q,   win_d;
  logic [5:0]            cnt_q,   cnt_d;
  logic [3:0]            good_q,  good_d;
  logic [3:0]            miss_q,  miss_d;
  logic [WD_W-1:0]       wd_q,    wd_d;
  logic [15:0]           left_q,  left_d;
  logic [15:0]           right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q,   ovr_d;

  link_sck_edge u_sck_edge (
    .clk       (clk),
    .reset     (reset),
    .sck_i     (sck),
    .sd_i      (sd),
    .bit_evt_o (w_evt),
    .bit_val_o (w_bit)
  );

  assign w_shift    = {win_q[FRAME_BITS-2:0], w_bit};
  assign w_hit      = marker_hit(w_shift);
  assign w_boundary = (cnt_q == LAST_BIT);
  assign w_timeout  = (wd_q == WD_LAST);
  assign w_accept   = valid_q & sample_ready;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    wd_d    = w_evt ? '0 : wd_q + WD_ONE;
    w_emit  = 1'b0;
    w_mute  = 1'b0;

    // A timeout outranks a coincident bit event, so that frame is never emitted
    if (w_timeout) begin
      state_d = S_HUNT;
      win_d   = '0;
      cnt_d   = '0;
      good_d  = '0;
      miss_d  = '0;
      wd_d    = '0;
      w_mute  = (state_q == S_LOCKED);
    end else if (w_evt) begin
      win_d = w_shift;
      cnt_d = w_boundary ? 6'd0 : cnt_q + 6'd1;
      case (state_q)
        S_HUNT: begin
          cnt_d = '0;
          if (w_hit) begin
            state_d = S_CHECK;
            good_d  = 4'd1;
            win_d   = '0;
          end
        end
        S_CHECK: begin
          if (w_boundary) begin
            if (w_hit) begin
              good_d = good_q + 4'd1;
              if (good_d == LOCK_N) begin
                state_d = S_LOCKED;
                miss_d  = '0;
                w_emit  = 1'b1;
              end
            end else begin
              state_d = S_HUNT;
            end
          end
        end
        S_LOCKED: begin
          if (w_boundary) begin
            if (w_hit) begin
              miss_d = '0;
              w_emit = 1'b1;
            end else begin
              miss_d = miss_q + 4'd1;
              if (miss_d >= MISS_N) begin
                state_d = S_HUNT;
                miss_d  = '0;
                w_mute  = 1'b1;
              end
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (w_mute) begin
      left_d  = '0;
      right_d = '0;
      valid_d = 1'b0;
    end else if (w_emit) begin
      left_d  = w_shift[31:16];
      right_d = w_shift[15:0];
      valid_d = 1'b1;
      ovr_d   = valid_q & ~sample_ready;
    end else if (w_accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HUNT;
      win_q   <= '0;
      cnt_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      wd_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      wd_q    <= wd_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign locked       = (state_q == S_LOCKED);

`ifdef AUDIO_LINK_ERRCNT_EN
  logic       w_err_inc;
  logic [7:0] err_q;

  assign w_err_inc = w_timeout |
                     (w_evt & w_boundary & ~w_hit & (state_q == S_LOCKED));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 8'd0;
    end else if (w_err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_link_supervisor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_audio_link_supervisor : directed bench with a behavioural model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_audio_link_supervisor;

  localparam int T_CYC  = 65536;
  localparam int N_LOCK = 4;
  localparam int N_MISS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        sd;
  logic        sample_ready;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        sample_valid;
  logic        overrun;
  logic        locked;
`ifdef AUDIO_LINK_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  audio_link_supervisor #(
    .LOCK_FRAMES    (N_LOCK),
    .MISS_MAX       (N_MISS),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .sd           (sd),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .locked       (locked)
`ifdef AUDIO_LINK_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, one step per clk ----------------
  localparam int M_HUNT = 0, M_CHECK = 1, M_LOCK = 2;

  int          cyc    = 0;
  int          ev_due = -1;
  bit          ev_bit = 1'b0;
  int          m_mode = M_HUNT;
  logic [39:0] m_win  = '0;
  int          m_pos  = 0;
  int          m_good = 0;
  int          m_miss = 0;
  int          m_idle = 0;
  int          m_err  = 0;
  logic [15:0] m_l    = '0;
  logic [15:0] m_r    = '0;
  bit          m_valid = 1'b0;
  bit          m_ovr   = 1'b0;

  always @(posedge clk) begin : model
    bit          ev, tmo, emit, mute;
    logic [39:0] w;
    cyc  = cyc + 1;
    ev   = (cyc == ev_due);
    emit = 1'b0;
    mute = 1'b0;
    w    = '0;
    if (reset) begin
      m_mode = M_HUNT; m_win = '0; m_pos = 0; m_good = 0; m_miss = 0;
      m_idle = 0; m_err = 0; m_l = '0; m_r = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      tmo    = (m_idle + 1 >= T_CYC);
      m_idle = (ev || tmo) ? 0 : m_idle + 1;
      if (tmo) begin
        mute   = (m_mode == M_LOCK);
        m_mode = M_HUNT; m_win = '0; m_pos = 0; m_good = 0; m_miss = 0;
        if (m_err < 255) m_err++;
      end else if (ev) begin
        w     = {m_win[38:0], ev_bit};
        m_win = w;
        if (m_mode == M_HUNT) begin
          if (w[39:32] == 8'hAA) begin
            m_mode = M_CHECK; m_pos = 0; m_good = 1; m_win = '0;
          end
        end else if (m_pos < 39) begin
          m_pos++;
        end else begin
          m_pos = 0;
          if (m_mode == M_CHECK) begin
            if (w[39:32] != 8'hAA) m_mode = M_HUNT;
            else begin
              m_good++;
              if (m_good == N_LOCK) begin m_mode = M_LOCK; m_miss = 0; emit = 1'b1; end
            end
          end else if (w[39:32] == 8'hAA) begin
            emit = 1'b1; m_miss = 0;
          end else begin
            m_miss++;
            if (m_err < 255) m_err++;
            if (m_miss >= N_MISS) begin m_mode = M_HUNT; m_miss = 0; mute = 1'b1; end
          end
        end
      end
      m_ovr = 1'b0;
      if (mute) begin
        m_l = '0; m_r = '0; m_valid = 1'b0;
      end else if (emit) begin
        m_ovr   = m_valid && !sample_ready;
        m_l     = w[31:16];
        m_r     = w[15:0];
        m_valid = 1'b1;
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("left_out",     {16'd0, left_out},  {16'd0, m_l});
      chk("right_out",    {16'd0, right_out}, {16'd0, m_r});
      chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
      chk("overrun",      {31'd0, overrun},   {31'd0, m_ovr});
      chk("locked",       {31'd0, locked},    {31'd0, (m_mode == M_LOCK)});
`ifdef AUDIO_LINK_ERRCNT_EN
      chk("err_count",    {24'd0, err_count}, m_err);
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [39:0] frame(input logic [7:0] mk, input logic [15:0] l,
                                        input logic [15:0] r);
    return {mk, l, r};
  endfunction

  // Entered and left just after a posedge; sck low 3 clk then high 3 clk.
  task automatic send_bit(input bit b);
    sck = 1'b0;
    sd  = b;
    repeat (3) @(posedge clk);
    #1;
    sck    = 1'b1;
    ev_due = cyc + 3;
    ev_bit = b;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 39; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; sd = 1'b0; sample_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst_left",   {16'd0, left_out}, 32'h0);
    chk("rst_valid",  {31'd0, sample_valid}, 32'h0);
    chk("rst_locked", {31'd0, locked}, 32'h0);
    chk("rst_ovr",    {31'd0, overrun}, 32'h0);

    // acquisition: 4 clean frames
    for (int k = 0; k < 3; k++) send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("acq_no_lock",  {31'd0, locked}, 32'h0);
    chk("acq_no_valid", {31'd0, sample_valid}, 32'h0);
    send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("acq_locked", {31'd0, locked}, 32'h1);
    chk("acq_valid",  {31'd0, sample_valid}, 32'h1);
    chk("acq_left",   {16'd0, left_out}, 32'h1234);
    chk("acq_right",  {16'd0, right_out}, 32'hABCD);
    tick(1);
    chk("acq_accepted", {31'd0, sample_valid}, 32'h0);

    // single bad marker, then recovery
    send_frame(frame(8'hAB, 16'h5678, 16'h9ABC));
    chk("miss1_locked", {31'd0, locked}, 32'h1);
    chk("miss1_valid",  {31'd0, sample_valid}, 32'h0);
    send_frame(frame(8'hAA, 16'h0001, 16'hFFFF));
    chk("rec_valid", {31'd0, sample_valid}, 32'h1);
    chk("rec_left",  {16'd0, left_out}, 32'h0001);
    chk("rec_right", {16'd0, right_out}, 32'hFFFF);
`ifdef AUDIO_LINK_ERRCNT_EN
    chk("rec_errcnt", {24'd0, err_count}, 32'd1);
`endif

    // two bad markers -> hunt + mute, then relock
    send_frame(frame(8'hAB, 16'h1234, 16'hABCD));
    chk("miss2a_locked", {31'd0, locked}, 32'h1);
    send_frame(frame(8'hAB, 16'h1234, 16'hABCD));
    chk("miss2b_locked", {31'd0, locked}, 32'h0);
    chk("miss2b_left",   {16'd0, left_out}, 32'h0);
    chk("miss2b_right",  {16'd0, right_out}, 32'h0);
    for (int k = 0; k < 3; k++) send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("relock_pending", {31'd0, locked}, 32'h0);
    send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("relock_done", {31'd0, locked}, 32'h1);
    chk("relock_left", {16'd0, left_out}, 32'h1234);

    // watchdog: sck held low
    sck = 1'b0;
    tick(T_CYC - 10);
    chk("wd_before", {31'd0, locked}, 32'h1);
    tick(20);
    chk("wd_locked", {31'd0, locked}, 32'h0);
    chk("wd_left",   {16'd0, left_out}, 32'h0);
    chk("wd_right",  {16'd0, right_out}, 32'h0);
    chk("wd_valid",  {31'd0, sample_valid}, 32'h0);
`ifdef AUDIO_LINK_ERRCNT_EN
    chk("wd_errcnt", {24'd0, err_count}, 32'd4);
`endif

    // overrun with consumer stalled
    for (int k = 0; k < 4; k++) send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("ovr_locked", {31'd0, locked}, 32'h1);
    tick(1);
    sample_ready = 1'b0;
    send_frame(frame(8'hAA, 16'h1111, 16'h1111));
    chk("ovr_first_valid", {31'd0, sample_valid}, 32'h1);
    chk("ovr_first_pulse", {31'd0, overrun}, 32'h0);
    send_frame(frame(8'hAA, 16'h2222, 16'h2222));
    chk("ovr_pulse", {31'd0, overrun}, 32'h1);
    chk("ovr_left",  {16'd0, left_out}, 32'h2222);
    tick(1);
    chk("ovr_one_shot", {31'd0, overrun}, 32'h0);
    tick(5);
    chk("ovr_held_valid", {31'd0, sample_valid}, 32'h1);
    sample_ready = 1'b1;
    tick(1);
    chk("ovr_released", {31'd0, sample_valid}, 32'h0);

    // bit slip while in CHECK
    sck = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("slip_rst_left", {16'd0, left_out}, 32'h0);
    send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    send_bit(1'b0);
    for (int k = 0; k < 3; k++) send_frame(frame(8'hAA, 16'h1234, 16'hABCD));
    chk("slip_no_lock", {31'd0, locked}, 32'h0);
    send_frame(frame(8'hAA, 16'h0F0F, 16'h7777));
    chk("slip_locked", {31'd0, locked}, 32'h1);
    chk("slip_left",   {16'd0, left_out}, 32'h0F0F);
    chk("slip_right",  {16'd0, right_out}, 32'h7777);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
